// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, CP0 exception codes and the
// MEM-stage control bundle carried by the EX/MEM and MEM/WB registers.
package pipe_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } mem_ctrl_t;

  // Control bundle of a bubble: nothing is written anywhere.
  function automatic mem_ctrl_t ctrl_bubble();
    mem_ctrl_t c;
    c = '0;
    return c;
  endfunction

endpackage

// File: rtl/exc_capture.sv
// Sticky exception request with EPC and cause code. The first trap wins while
// a request is pending; a trap arriving together with the ack replaces it.
module exc_capture #(
  parameter int DW = 32,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          trap,
  input  logic [DW-1:0] trap_pc,
  input  logic [CW-1:0] trap_code,
  input  logic          ack,
  output logic          req,
  output logic [DW-1:0] epc,
  output logic [CW-1:0] code
);

  logic          req_reg;
  logic [DW-1:0] epc_reg;
  logic [CW-1:0] code_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_reg  <= 1'b0;
      epc_reg  <= '0;
      code_reg <= '0;
    end else if (trap && (!req_reg || ack)) begin
      req_reg  <= 1'b1;
      epc_reg  <= trap_pc;
      code_reg <= trap_code;
    end else if (ack) begin
      req_reg  <= 1'b0;
    end
  end

  assign req  = req_reg;
  assign epc  = epc_reg;
  assign code = code_reg;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: latches EX results for MEM, squashes side effects
// of trapping overflows and raises the overflow exception request.
module ex_mem_reg
  import pipe_pkg::*;
#(
  parameter int         DW     = pipe_pkg::DW,
  parameter int         RW     = pipe_pkg::RW,
  parameter logic [4:0] EXC_OV = pipe_pkg::EXC_OV
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_pc,
  input  logic [DW-1:0] ex_alu_out,
  input  logic          ex_overflow,
  input  logic          ex_ovf_trap,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_mem_to_reg,
  input  logic          ex_link,
  input  logic          exc_ack,
  output logic          mem_valid,
  output logic [DW-1:0] mem_pc,
  output logic [DW-1:0] mem_result,
  output logic [DW-1:0] mem_store_data,
  output logic [RW-1:0] mem_rd,
  output logic          mem_reg_write,
  output logic          mem_mem_read,
  output logic          mem_mem_write,
  output logic          mem_mem_to_reg,
  output logic          fwd_en,
  output logic          exc_req,
  output logic [DW-1:0] exc_epc,
  output logic [4:0]    exc_code
);

  logic          valid_reg;
  logic [DW-1:0] pc_reg;
  logic [DW-1:0] result_reg;
  logic [DW-1:0] store_data_reg;
  logic [RW-1:0] rd_reg;
  mem_ctrl_t     ctrl_reg;

  logic          load;
  logic          trap;
  logic [DW-1:0] result_next;
  mem_ctrl_t     ctrl_next;

  assign load        = ~stall & ~flush;
  assign trap        = ex_valid & ex_ovf_trap & ex_overflow;
  assign result_next = ex_link ? (ex_pc + DW'(8)) : ex_alu_out;

  // A trapping instruction stays visible in MEM (valid, for EPC tracking)
  // but must not touch the register file or memory.
  always_comb begin
    ctrl_next            = ctrl_bubble();
    ctrl_next.reg_write  = ex_reg_write & (ex_rd != '0) & ~trap;
    ctrl_next.mem_read   = ex_mem_read & ~trap;
    ctrl_next.mem_write  = ex_mem_write & ~trap;
    ctrl_next.mem_to_reg = ex_mem_to_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      pc_reg         <= '0;
      result_reg     <= '0;
      store_data_reg <= '0;
      rd_reg         <= '0;
      ctrl_reg       <= ctrl_bubble();
    end else if (flush) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= ctrl_bubble();
    end else if (!stall) begin
      valid_reg <= ex_valid;
      if (ex_valid) begin
        pc_reg         <= ex_pc;
        result_reg     <= result_next;
        store_data_reg <= ex_store_data;
        rd_reg         <= ex_rd;
        ctrl_reg       <= ctrl_next;
      end else begin
        ctrl_reg <= ctrl_bubble();
      end
    end
  end

  exc_capture #(
    .DW(DW),
    .CW(5)
  ) u_exc_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .trap      (load & trap),
    .trap_pc   (ex_pc),
    .trap_code (EXC_OV),
    .ack       (exc_ack),
    .req       (exc_req),
    .epc       (exc_epc),
    .code      (exc_code)
  );

  assign mem_valid      = valid_reg;
  assign mem_pc         = pc_reg;
  assign mem_result     = result_reg;
  assign mem_store_data = store_data_reg;
  assign mem_rd         = rd_reg;
  assign mem_reg_write  = ctrl_reg.reg_write;
  assign mem_mem_read   = ctrl_reg.mem_read;
  assign mem_mem_write  = ctrl_reg.mem_write;
  assign mem_mem_to_reg = ctrl_reg.mem_to_reg;
  assign fwd_en         = ctrl_reg.reg_write & ~ctrl_reg.mem_to_reg;

endmodule
